// File: rtl/mips_data_responder_pkg.sv
// rtl/mips_data_responder_pkg.sv - address map, register bit positions and decode helper
package mips_data_responder_pkg;

    localparam logic [15:0] MMIO_PAGE  = 16'hFFFF;
    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_SW     = 16'h0004;
    localparam logic [15:0] OFF_TCOUNT = 16'h0010;
    localparam logic [15:0] OFF_TCMP   = 16'h0014;
    localparam logic [15:0] OFF_TCTRL  = 16'h0018;
    localparam logic [15:0] OFF_STATUS = 16'h001C;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_IRQ_EN = 1;
    localparam int ST_MATCH     = 2;
    localparam int ST_MISALIGN  = 3;
    localparam int ST_UNMAPPED  = 4;

    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        T_NONE, T_RAM, T_LED, T_SW, T_TCOUNT, T_TCMP, T_TCTRL, T_STATUS
    } target_e;

    // Register page decode only; RAM range and alignment are checked by the caller.
    function automatic target_e mmio_decode(input logic [31:0] addr);
        mmio_decode = T_NONE;
        if (addr[31:16] == MMIO_PAGE) begin
            case (addr[15:0])
                OFF_LED:    mmio_decode = T_LED;
                OFF_SW:     mmio_decode = T_SW;
                OFF_TCOUNT: mmio_decode = T_TCOUNT;
                OFF_TCMP:   mmio_decode = T_TCMP;
                OFF_TCTRL:  mmio_decode = T_TCTRL;
                OFF_STATUS: mmio_decode = T_STATUS;
                default:    mmio_decode = T_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/mips_data_responder_mmio_timer.sv
// rtl/mips_data_responder_mmio_timer.sv - free-running timer with compare, reload and sticky match flag
module mips_data_responder_mmio_timer
    import mips_data_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_tcount_i,
    input  logic        wr_tcmp_i,
    input  logic        wr_tctrl_i,
    input  logic        clr_match_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcount_o,
    output logic [31:0] tcmp_o,
    output logic [1:0]  tctrl_o,
    output logic        match_o
);

    logic [31:0] tcount_q, tcount_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic [1:0]  tctrl_q, tctrl_d;
    logic        match_q, match_d;
    logic        match_hit;

    always_comb begin
        match_hit = tctrl_q[TCTRL_EN] && (tcount_q == tcmp_q);
        tcount_d  = tcount_q;
        tcmp_d    = tcmp_q;
        tctrl_d   = tctrl_q;
        // A CPU write to TCOUNT beats the reload, which beats the increment.
        if (wr_tcount_i) begin
            tcount_d = wdata_i;
        end else if (match_hit) begin
            tcount_d = '0;
        end else if (tctrl_q[TCTRL_EN]) begin
            tcount_d = tcount_q + 32'd1;
        end
        if (wr_tcmp_i) begin
            tcmp_d = wdata_i;
        end
        if (wr_tctrl_i) begin
            tctrl_d = wdata_i[1:0];
        end
        // Set wins over a simultaneous write-1-to-clear.
        match_d = match_hit | (match_q & ~clr_match_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tcount_q <= '0;
            tcmp_q   <= TCMP_RESET;
            tctrl_q  <= '0;
            match_q  <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            tctrl_q  <= tctrl_d;
            match_q  <= match_d;
        end
    end

    assign tcount_o = tcount_q;
    assign tcmp_o   = tcmp_q;
    assign tctrl_o  = tctrl_q;
    assign match_o  = match_q;

endmodule

// File: rtl/mips_data_responder.sv
// rtl/mips_data_responder.sv - data-side responder: word RAM, MMIO page and error flags
module mips_data_responder
    import mips_data_responder_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int LED_W  = 16,
    parameter int SW_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       memaddr,
    input  logic [31:0]       memwritedata,
    output logic [31:0]       memreaddata,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  led,
    output logic              irq,
    output logic              bus_err
);

    logic [31:0] ram [0:(2**RAM_AW)-1];

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic             misalign_q, misalign_d;
    logic             unmapped_q, unmapped_d;

    logic              misaligned;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    target_e           tgt;
    logic              wr_ok;
    logic              wr_st;

    logic [31:0] tcount, tcmp;
    logic [1:0]  tctrl;
    logic        match_flag;
    logic [31:0] status;

    always_comb begin
        misaligned = |memaddr[1:0];
        ram_hit    = (memaddr[31:RAM_AW+2] == '0);
        ram_idx    = memaddr[RAM_AW+1:2];
        tgt        = ram_hit ? T_RAM : mmio_decode(memaddr);
        wr_ok      = memwrite & ~misaligned;
        wr_st      = wr_ok && (tgt == T_STATUS);
    end

    assign status = {27'd0, unmapped_q, misalign_q, match_flag, 2'b00};

    // Misaligned reads return 0 silently: the core drives memaddr on every instruction.
    always_comb begin
        memreaddata = '0;
        if (!misaligned) begin
            case (tgt)
                T_RAM:    memreaddata = ram[ram_idx];
                T_LED:    memreaddata = 32'(led_q);
                T_SW:     memreaddata = 32'(sw_sync_q);
                T_TCOUNT: memreaddata = tcount;
                T_TCMP:   memreaddata = tcmp;
                T_TCTRL:  memreaddata = {30'd0, tctrl};
                T_STATUS: memreaddata = status;
                default:  memreaddata = '0;
            endcase
        end
    end

    always_comb begin
        led_d = led_q;
        if (wr_ok && (tgt == T_LED)) begin
            led_d = memwritedata[LED_W-1:0];
        end
        misalign_d = (misalign_q & ~(wr_st & memwritedata[ST_MISALIGN])) | (memwrite & misaligned);
        unmapped_d = (unmapped_q & ~(wr_st & memwritedata[ST_UNMAPPED])) | (wr_ok && (tgt == T_NONE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            misalign_q <= 1'b0;
            unmapped_q <= 1'b0;
        end else begin
            led_q      <= led_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            misalign_q <= misalign_d;
            unmapped_q <= unmapped_d;
        end
    end

    // RAM contents survive reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok && (tgt == T_RAM)) begin
            ram[ram_idx] <= memwritedata;
        end
    end

    mips_data_responder_mmio_timer u_timer (
        .clk_i       (clk),
        .reset_i     (reset),
        .wr_tcount_i (wr_ok && (tgt == T_TCOUNT)),
        .wr_tcmp_i   (wr_ok && (tgt == T_TCMP)),
        .wr_tctrl_i  (wr_ok && (tgt == T_TCTRL)),
        .clr_match_i (wr_st & memwritedata[ST_MATCH]),
        .wdata_i     (memwritedata),
        .tcount_o    (tcount),
        .tcmp_o      (tcmp),
        .tctrl_o     (tctrl),
        .match_o     (match_flag)
    );

    assign led     = led_q;
    assign irq     = match_flag & tctrl[TCTRL_IRQ_EN];
    assign bus_err = misalign_q | unmapped_q;

endmodule

// File: tb/tb_mips_data_responder.sv
// tb/tb_mips_data_responder.sv - directed plus randomized checks against a behavioural model
module tb_mips_data_responder;
    import mips_data_responder_pkg::*;

    localparam logic [31:0] A_LED    = {MMIO_PAGE, OFF_LED};
    localparam logic [31:0] A_SW     = {MMIO_PAGE, OFF_SW};
    localparam logic [31:0] A_TCOUNT = {MMIO_PAGE, OFF_TCOUNT};
    localparam logic [31:0] A_TCMP   = {MMIO_PAGE, OFF_TCMP};
    localparam logic [31:0] A_TCTRL  = {MMIO_PAGE, OFF_TCTRL};
    localparam logic [31:0] A_STATUS = {MMIO_PAGE, OFF_STATUS};
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mem [int];
    logic [15:0] m_led, m_sw1, m_sw2;
    logic [31:0] m_tcount, m_tcmp;
    logic [1:0]  m_tctrl;
    logic [4:0]  m_status;

    mips_data_responder dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .sw           (sw),
        .led          (led),
        .irq          (irq),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge of the responder, applied to the model from the inputs now on the pins.
    function automatic void model_edge();
        logic [31:0] nt;
        logic [4:0]  ns;
        bit          hit;
        if (reset) begin
            m_led = '0; m_sw1 = '0; m_sw2 = '0;
            m_tcount = '0; m_tcmp = 32'hFFFF_FFFF; m_tctrl = '0; m_status = '0;
            return;
        end
        hit = m_tctrl[0] && (m_tcount == m_tcmp);
        nt  = hit ? 32'd0 : (m_tctrl[0] ? m_tcount + 32'd1 : m_tcount);
        ns  = m_status;
        m_sw2 = m_sw1;
        m_sw1 = sw;
        if (memwrite) begin
            if (memaddr % 4 != 0) ns[3] = 1'b1;
            else if (memaddr < RAM_BYTES) m_mem[int'(memaddr / 4)] = memwritedata;
            else begin
                case (memaddr)
                    A_LED:    m_led = memwritedata[15:0];
                    A_SW:     ;
                    A_TCOUNT: nt = memwritedata;
                    A_TCMP:   m_tcmp = memwritedata;
                    A_TCTRL:  m_tctrl = memwritedata[1:0];
                    A_STATUS: ns = ns & ~memwritedata[4:0];
                    default:  ns[4] = 1'b1;
                endcase
            end
        end
        if (hit) ns[2] = 1'b1;
        m_tcount = nt;
        m_status = ns;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a % 4 != 0) return 32'd0;
        if (a < RAM_BYTES) begin
            if (m_mem.exists(int'(a / 4))) return m_mem[int'(a / 4)];
            known = 1'b0;
            return 32'd0;
        end
        case (a)
            A_LED:    return {16'd0, m_led};
            A_SW:     return {16'd0, m_sw2};
            A_TCOUNT: return m_tcount;
            A_TCMP:   return m_tcmp;
            A_TCTRL:  return {30'd0, m_tctrl};
            A_STATUS: return {27'd0, m_status};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("led", {16'd0, led}, {16'd0, m_led});
        chk("irq", {31'd0, irq}, {31'd0, m_status[2] & m_tctrl[1]});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_status[3] | m_status[4]});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        memaddr = a;
        memwritedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        bit known;
        logic [31:0] e;
        memaddr = a;
        #1;
        e = m_read(a, known);
        if (known) chk(tag, memreaddata, e);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] e);
        memaddr = a;
        #1;
        chk(tag, memreaddata, e);
    endtask

    task automatic run_until_tcount(input logic [31:0] v);
        int n = 0;
        while (m_tcount != v && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] regs [6];
        regs = '{A_LED, A_SW, A_TCOUNT, A_TCMP, A_TCTRL, A_STATUS};
        case ($urandom_range(0, 5))
            0, 1:    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            2, 5:    return regs[$urandom_range(0, 5)];
            3:       return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            default: return ($urandom_range(0, 1) == 0) ? {MMIO_PAGE, 16'h0020}
                                                         : {2'b10, 28'($urandom), 2'b00};
        endcase
    endfunction

    initial begin
        logic [31:0] a, d;
        reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0; sw = '0;
        tick();
        tick();
        reset = 1'b0;

        rd_exp("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
        rd_exp("rst_tcount", A_TCOUNT, 32'd0);
        rd_exp("rst_tctrl", A_TCTRL, 32'd0);
        rd_exp("rst_status", A_STATUS, 32'd0);

        wr(32'h14, 32'h1111_1111);
        wr(32'h04, 32'h2222_2222);
        wr(32'h10, 32'hDEAD_BEEF);
        rd_exp("ram_load", 32'h10, 32'hDEAD_BEEF);
        rd_exp("ram_neighbour", 32'h14, 32'h1111_1111);

        wr(A_LED, 32'h0000_A5A5);
        chk("led_write", {16'd0, led}, 32'h0000_A5A5);
        rd_exp("led_read", A_LED, 32'h0000_A5A5);

        sw = 16'h1234;
        memaddr = A_SW;
        tick();
        rd_exp("sw_edge1", A_SW, 32'd0);
        tick();
        rd_exp("sw_edge2", A_SW, 32'h0000_1234);

        wr(A_TCMP, 32'd5);
        wr(A_TCTRL, 32'h3);
        for (int i = 0; i <= 5; i++) begin
            rd_exp("tcount_seq", A_TCOUNT, i);
            tick();
        end
        rd_exp("tcount_reload", A_TCOUNT, 32'd0);
        rd_exp("match_set", A_STATUS, 32'h4);
        chk("irq_on", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'h4);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        run_until_tcount(32'd5);
        rd_exp("tcount_at_cmp", A_TCOUNT, 32'd5);
        wr(A_STATUS, 32'h4);
        rd_exp("set_wins", A_STATUS, 32'h4);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'h4);

        wr(A_TCOUNT, 32'h100);
        rd_exp("tcount_write", A_TCOUNT, 32'h100);
        tick();
        rd_exp("tcount_inc", A_TCOUNT, 32'h101);

        wr(32'h06, 32'h3333_3333);
        rd_exp("misalign_drop", 32'h04, 32'h2222_2222);
        chk("misalign_err", {31'd0, bus_err}, 32'd1);
        rd_exp("misalign_rd", 32'h13, 32'd0);
        memaddr = A_STATUS;
        #1;
        chk("misalign_flag", {31'd0, memreaddata[ST_MISALIGN]}, 32'd1);
        wr(32'h8000_0000, 32'h5555_5555);
        memaddr = A_STATUS;
        #1;
        chk("unmapped_flag", {31'd0, memreaddata[ST_UNMAPPED]}, 32'd1);
        rd_exp("unmapped_rd", 32'h8000_0000, 32'd0);
        tick();
        rd("status_after_rd", A_STATUS);
        wr(A_STATUS, 32'h1C);
        rd("status_clear", A_STATUS);

        wr(A_TCMP, 32'd1);
        wr(A_TCOUNT, 32'd0);
        tick();
        tick();
        wr(A_TCMP, 32'd100);
        run_until_tcount(32'd3);
        rd_exp("pre_reset_tcount", A_TCOUNT, 32'd3);
        rd_exp("pre_reset_match", A_STATUS, 32'h4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_exp("post_reset_tcount", A_TCOUNT, 32'd0);
        rd_exp("post_reset_status", A_STATUS, 32'd0);
        chk("post_reset_irq", {31'd0, irq}, 32'd0);
        chk("post_reset_led", {16'd0, led}, 32'd0);
        rd_exp("ram_survives", 32'h10, 32'hDEAD_BEEF);
        reset = 1'b1;
        wr(A_LED, 32'hFFFF);
        reset = 1'b0;
        chk("wr_in_reset", {16'd0, led}, 32'd0);

        wr(A_TCTRL, 32'h3);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            a = pick_addr();
            d = $urandom;
            if (a == A_TCMP) d = d & 32'hF;
            if (a == A_TCOUNT) d = d & 32'h7;
            if (a == A_TCTRL && $urandom_range(0, 3) != 0) d = d | 32'h1;
            if ($urandom_range(0, 9) < 4) begin
                wr(a, d);
            end else begin
                rd("rand_rd", a);
                rd("rand_tcount", A_TCOUNT);
                tick();
            end
            if (i % 16 == 0) rd("rand_status", A_STATUS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
